fifo_word_unpacker: RTL and testbench
=====================================

FIFO_WORD_UNPACKER -- requirements
Module: fifo_word_unpacker

Interface
REQ-001 SHALL have parameter data_width, default 32, FIFO word width; must be a multiple of out_width and at least 2*out_width.
REQ-002 SHALL have parameter out_width, default 8, output beat width.
REQ-003 SHALL have parameter msb_first, default 0: 0 sends the least-significant slice first; 1 sends the most-significant slice first.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port en, input, 1, permits new FIFO fetches.
REQ-007 SHALL have port fifo_empty, input, 1, empty flag from the upstream synchronous FIFO.
REQ-008 SHALL have port fifo_data, input, data_width, registered FIFO read data, valid one cycle after fifo_rd_ena.
REQ-009 SHALL have port fifo_rd_ena, output, 1, read strobe to the FIFO; the FIFO chip select is tied high externally.
REQ-010 SHALL have port out_data, output, out_width, current beat.
REQ-011 SHALL have port out_valid, output, 1, beat valid.
REQ-012 SHALL have port out_ready, input, 1, sink accepts the beat.
REQ-013 SHALL have port out_last, output, 1, high on the final beat of a word.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port word_cnt, output, 16, count of fully transmitted words; wraps 0xFFFF->0.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD and SEND; BEATS = data_width/out_width.
REQ-017 SHALL drive fifo_rd_ena combinationally as (en && !fifo_empty) && (state==IDLE, or state==SEND with the last beat accepted this cycle); in that cycle, next state SHALL be LOAD.
REQ-018 SHALL, in LOAD, capture fifo_data into the shift register, clear the beat index, and go to SEND; fifo_rd_ena SHALL be 0 in LOAD.
REQ-019 SHALL give a latency of 2 cycles from fifo_rd_ena high to the first out_valid high.
REQ-020 SHALL hold out_valid high throughout SEND; out_data and out_last SHALL be stable until out_valid && out_ready.
REQ-021 SHALL, on each accepted beat, increment the beat index and shift the next slice into place per msb_first.
REQ-022 SHALL assert out_last exactly when beat index == BEATS-1.
REQ-023 SHALL, on the last beat accepted, increment word_cnt; next state SHALL be LOAD if a fetch is issued per REQ-017, else IDLE.
REQ-024 SHALL give back-to-back words exactly one bubble cycle (LOAD) between the last beat and the next first beat.
REQ-025 SHALL NOT abort the word in flight when en is deasserted during SEND; only further fetches SHALL stop.
REQ-026 SHALL NOT change behaviour in SEND if fifo_empty changes; it SHALL be sampled only at fetch decisions.
REQ-027 SHALL never assert fifo_rd_ena while fifo_empty=1; no underflow is possible.
REQ-028 SHALL keep out_valid low in IDLE and LOAD.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, set state=IDLE, beat index=0, shift register=0, word_cnt=0.
REQ-030 SHALL, during reset, force out_valid=0, out_last=0, out_data=0, busy=0 and fifo_rd_ena=0.
REQ-031 SHALL discard a word interrupted by reset mid-SEND; that word SHALL not be counted in word_cnt.

Structure
REQ-032 SHALL place the FSM state encoding (2-bit) and the BEATS/index-width helper constants in the shared package fifo_pkg.
REQ-033 SHALL be implemented as a single module with no sub-modules; the beat index width SHALL be $clog2(BEATS).

Verification
REQ-034 Bench SHALL cover: reset, then empty=0 with data 0xA1B2C3D4, ready=1, msb_first=0 -> rd_ena pulse at T; bytes D4,C3,B2,A1 at T+2..T+5; out_last at T+5; word_cnt=1.
REQ-035 Bench SHALL cover: msb_first=1, same data -> bytes A1,B2,C3,D4 in order.
REQ-036 Bench SHALL cover: ready toggling 1,0,0,1 during a word -> each byte held stable while ready=0; no bytes dropped or duplicated.
REQ-037 Bench SHALL cover: 3 queued words with ready=1 -> 12 beats with exactly one idle cycle between words; word_cnt=3; rd_ena never high while empty=1.
REQ-038 Bench SHALL cover: en dropped at the second byte -> current word completes, then IDLE with no further rd_ena.
REQ-039 Bench SHALL cover: rst=0 at the third byte -> next cycle out_valid=0, busy=0, word_cnt unchanged (0).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO word unpacker.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic int calc_beats(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    function automatic int calc_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_unpacker.sv
// Fetches words from a registered-read FIFO and emits them as out_width beats
// with valid/ready handshake, optionally most-significant slice first.
//
// state | meaning
// IDLE  | no word held; fetch when enabled and FIFO not empty
// LOAD  | FIFO read data valid this cycle; capture into shift register
// SEND  | presenting beats; on last accepted beat fetch again or go idle
module fifo_word_unpacker
    import fifo_pkg::*;
#(
    parameter int data_width = 32,
    parameter int out_width  = 8,
    parameter int msb_first  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    output logic                  fifo_rd_ena,
    output logic [out_width-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           word_cnt
);

    localparam int BEATS = calc_beats(data_width, out_width);
    localparam int IDX_W = calc_idx_w(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    state_t                  state;
    logic [IDX_W-1:0]        beat_idx;
    logic [data_width-1:0]   shreg;
    logic [out_width-1:0]    slice;
    logic                    accept;
    logic                    last_accept;
    logic                    fetch;

    assign accept      = (state == ST_SEND) && out_ready;
    assign last_accept = accept && (beat_idx == LAST_IDX);
    // Reset gates every output so nothing leaks while rst is held low.
    assign fetch       = rst && en && !fifo_empty &&
                         ((state == ST_IDLE) || last_accept);

    assign fifo_rd_ena = fetch;
    assign out_valid   = rst && (state == ST_SEND);
    assign out_last    = out_valid && (beat_idx == LAST_IDX);
    assign busy        = rst && (state != ST_IDLE);

    always_comb begin
        slice = shreg[out_width-1:0];
        if (msb_first != 0) begin
            slice = shreg[data_width-1 -: out_width];
        end
        out_data = rst ? slice : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
            shreg    <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg    <= fifo_data;
                    beat_idx <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept) begin
                        if (beat_idx == LAST_IDX) begin
                            word_cnt <= word_cnt + 16'd1;
                            beat_idx <= '0;
                            state    <= fetch ? ST_LOAD : ST_IDLE;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                            shreg    <= (msb_first != 0) ? (shreg << out_width)
                                                         : (shreg >> out_width);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench: two unpackers (LSB-first and MSB-first) against a
// queue-based FIFO model and a beat-list reference model.
module tb_fifo_word_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        out_ready;

    logic        rd_l, rd_m;
    logic [7:0]  data_l, data_m;
    logic        valid_l, valid_m;
    logic        last_l, last_m;
    logic        busy_l, busy_m;
    logic [15:0] wcnt_l, wcnt_m;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.data_width(32), .out_width(8), .msb_first(0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_ena(rd_l), .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .out_last(last_l), .busy(busy_l), .word_cnt(wcnt_l)
    );

    fifo_word_unpacker #(.data_width(32), .out_width(8), .msb_first(1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_ena(rd_m), .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
        .out_last(last_m), .busy(busy_m), .word_cnt(wcnt_m)
    );

    typedef struct {
        logic [31:0] w;
        int          idx;
    } beat_t;

    logic [31:0] fq[$];     // upstream FIFO contents
    beat_t       bq[$];     // beats still owed by the DUT, in order
    int          ready_cyc;
    int          cyc;
    int          rd_count;
    logic [15:0] wcnt;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, apply FIFO read data.
    task automatic tick();
        int          nb;
        logic        v_exp, l_exp, rd_exp, b_exp, load;
        logic [31:0] w;
        beat_t       f;
        @(negedge clk);
        nb     = bq.size();
        v_exp  = rst && (nb > 0) && (cyc >= ready_cyc);
        l_exp  = v_exp && (nb == 1);
        rd_exp = rst && en && !fifo_empty && ((nb == 0) || (l_exp && out_ready));
        b_exp  = rst && (nb > 0);
        chk("rd_lsb",    32'(rd_l),    32'(rd_exp));
        chk("rd_msb",    32'(rd_m),    32'(rd_exp));
        chk("valid_lsb", 32'(valid_l), 32'(v_exp));
        chk("valid_msb", 32'(valid_m), 32'(v_exp));
        chk("last_lsb",  32'(last_l),  32'(l_exp));
        chk("last_msb",  32'(last_m),  32'(l_exp));
        chk("busy_lsb",  32'(busy_l),  32'(b_exp));
        chk("busy_msb",  32'(busy_m),  32'(b_exp));
        chk("wcnt_lsb",  32'(wcnt_l),  32'(wcnt));
        chk("wcnt_msb",  32'(wcnt_m),  32'(wcnt));
        if (v_exp) begin
            f = bq[0];
            chk("data_lsb", 32'(data_l), 32'(8'(f.w >> (8 * f.idx))));
            chk("data_msb", 32'(data_m), 32'(8'(f.w >> (8 * (3 - f.idx)))));
        end
        if (!rst) begin
            chk("rst_data_lsb", 32'(data_l), 32'h0);
            chk("rst_data_msb", 32'(data_m), 32'h0);
        end
        load = 1'b0;
        w    = '0;
        if (!rst) begin
            bq.delete();
            wcnt = '0;
        end else begin
            if (v_exp && out_ready) begin
                void'(bq.pop_front());
                if (l_exp) wcnt = wcnt + 16'd1;
            end
            if (rd_exp) begin
                w = fq.pop_front();
                for (int i = 0; i < 4; i++) bq.push_back('{w: w, idx: i});
                ready_cyc = cyc + 2;
                rd_count++;
                load = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (load) fifo_data = w;
        fifo_empty = (fq.size() == 0);
        cyc++;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 10 && !valid_l; k++) tick();
        chk("wait_valid", 32'(valid_l), 32'h1);
    endtask

    int          rd_before;
    logic [15:0] wcnt_before;
    logic        rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; rd_count = 0; ready_cyc = 0; wcnt = '0;
        rst = 1'b0; en = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

        repeat (3) tick();
        chk("reset_wcnt", 32'(wcnt_l), 32'h0);
        chk("reset_busy", 32'(busy_l), 32'h0);
        rst = 1'b1;
        tick();

        // Reset asserted while the third byte is on the bus.
        push_word(32'h55667788);
        en = 1'b1; out_ready = 1'b1;
        wait_valid();
        tick(); tick();
        chk("third_byte", 32'(data_l), 32'h66);
        rst = 1'b0; en = 1'b0;
        tick();
        rst = 1'b1;
        chk("post_rst_valid", 32'(valid_l), 32'h0);
        chk("post_rst_busy",  32'(busy_l),  32'h0);
        chk("post_rst_wcnt",  32'(wcnt_l),  32'h0);
        tick();

        // Single word, ready held high.
        push_word(32'hA1B2C3D4);
        en = 1'b1; out_ready = 1'b1;
        repeat (8) tick();
        chk("single_wcnt_lsb", 32'(wcnt_l), 32'h1);
        chk("single_wcnt_msb", 32'(wcnt_m), 32'h1);

        // Ready toggling 1,0,0,1 during a word.
        push_word($urandom);
        wait_valid();
        for (int k = 0; k < 4; k++) begin
            out_ready = rdy_pat[k];
            tick();
        end
        out_ready = 1'b1;
        repeat (6) tick();
        chk("toggle_wcnt", 32'(wcnt_l), 32'h2);

        // Three queued words streamed back to back.
        en = 1'b0;
        wcnt_before = wcnt_l;
        for (int k = 0; k < 3; k++) push_word($urandom);
        tick();
        en = 1'b1;
        repeat (20) tick();
        chk("three_words", 32'(wcnt_l - wcnt_before), 32'h3);

        // en dropped on the second byte: word finishes, no further fetch.
        push_word($urandom);
        push_word($urandom);
        rd_before = rd_count;
        wait_valid();
        tick();
        en = 1'b0;
        repeat (10) tick();
        chk("en_drop_rd",    32'(rd_count - rd_before), 32'h1);
        chk("en_drop_left",  32'(fq.size()),            32'h1);
        chk("en_drop_idle",  32'(busy_l),               32'h0);
        en = 1'b1;
        repeat (8) tick();

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 79) != 0);
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) push_word($urandom);
            tick();
        end
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        repeat (30) tick();
        chk("drain_fifo", 32'(fq.size()), 32'h0);
        chk("drain_idle", 32'(busy_l),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
